// File: rtl/bram_line_unpacker_pkg.sv
// Shared constants, FSM state encoding and sizing helper for the BRAM line unpacker.
package bram_line_unpacker_pkg;

  localparam int unsigned DEF_BURST_LEN = 8;
  localparam int unsigned DEF_ADDR_W    = 10;
  localparam int unsigned DEF_LANE_W    = 16;
  localparam int unsigned DEF_OUT_W     = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_WAIT = 3'd2,
    ST_EMIT = 3'd3,
    ST_FIN  = 3'd4
  } state_t;

  // Width of a lane index; never narrower than one bit.
  function automatic int unsigned lane_cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bram_line_unpacker_shift_reg.sv
// Line-wide shift register: loads a whole BRAM line and shifts it right one lane at a time.
// Ports: clk, rst_n (async active-low), load (priority over shift), shift_en, d (line in), q (line out).
module bram_line_unpacker_shift_reg #(
  parameter int unsigned LANE_W    = 16,
  parameter int unsigned BURST_LEN = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        load,
  input  logic                        shift_en,
  input  logic [LANE_W*BURST_LEN-1:0] d,
  output logic [LANE_W*BURST_LEN-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (shift_en) begin
      q <= q >> LANE_W;
    end
  end

endmodule

// File: rtl/bram_line_unpacker.sv
// Fetches a run of wide BRAM lines and serializes each line, lane 0 first, into FIFO words.
// Ports:
//   clk, rst_n                 engine clock, async active-low reset
//   start, base_addr, line_count  launch request (sampled only in IDLE)
//   ram_rd_addr, ram_rd_data   BRAM port B (1-cycle read latency)
//   fifo_full, fifo_wr_en, fifo_wr_data  FIFO write side with backpressure
//   busy, done, words_sent     host status
module bram_line_unpacker
  import bram_line_unpacker_pkg::*;
#(
  parameter int unsigned BURST_LEN = DEF_BURST_LEN,
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned LANE_W    = DEF_LANE_W,
  parameter int unsigned OUT_W     = DEF_OUT_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           base_addr,
  input  logic [ADDR_W:0]             line_count,
  output logic [ADDR_W-1:0]           ram_rd_addr,
  input  logic [LANE_W*BURST_LEN-1:0] ram_rd_data,
  input  logic                        fifo_full,
  output logic                        fifo_wr_en,
  output logic [OUT_W-1:0]            fifo_wr_data,
  output logic                        busy,
  output logic                        done,
  output logic [ADDR_W+3:0]           words_sent
);

  localparam int unsigned LINE_W     = LANE_W * BURST_LEN;
  localparam int unsigned CNT_W      = ADDR_W + 1;
  localparam int unsigned WS_W       = ADDR_W + 4;
  localparam int unsigned LANE_CNT_W = lane_cnt_w(BURST_LEN);
  localparam logic [LANE_CNT_W-1:0] LAST_LANE = LANE_CNT_W'(BURST_LEN - 1);

  state_t                state_q, state_d;
  logic [LANE_CNT_W-1:0] lane_q;
  logic [CNT_W-1:0]      lines_left_q;
  logic [LINE_W-1:0]     shift_q;
  logic                  accept_c;
  logic                  wr_c;
  logic                  last_lane_c;

  assign accept_c    = (state_q == ST_IDLE) && start;
  assign wr_c        = (state_q == ST_EMIT) && !fifo_full;
  assign last_lane_c = (lane_q == LAST_LANE);

  // Lane 0 always sits in the low bits of the shift register.
  assign fifo_wr_data = OUT_W'(shift_q[LANE_W-1:0]);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and write strobe.
  always_comb begin
    state_d    = state_q;
    fifo_wr_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (line_count == '0) ? ST_FIN : ST_ADDR;
        end
      end
      ST_ADDR: state_d = ST_WAIT;
      ST_WAIT: state_d = ST_EMIT;
      ST_EMIT: begin
        fifo_wr_en = !fifo_full;
        if (!fifo_full && last_lane_c) begin
          state_d = (lines_left_q == CNT_W'(1)) ? ST_FIN : ST_ADDR;
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Address, line/lane counters and host status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_rd_addr  <= '0;
      lines_left_q <= '0;
      lane_q       <= '0;
      words_sent   <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
    end else begin
      // done is high for exactly the FIN cycle.
      done <= (state_d == ST_FIN);

      if (accept_c) begin
        ram_rd_addr  <= base_addr;
        lines_left_q <= line_count;
        words_sent   <= '0;
        busy         <= 1'b1;
      end

      if (state_q == ST_WAIT) begin
        lane_q <= '0;
      end

      if (wr_c) begin
        words_sent <= words_sent + WS_W'(1);
        if (last_lane_c) begin
          // Address wraps naturally modulo 2^ADDR_W.
          lane_q       <= '0;
          lines_left_q <= lines_left_q - CNT_W'(1);
          ram_rd_addr  <= ram_rd_addr + ADDR_W'(1);
        end else begin
          lane_q <= lane_q + LANE_CNT_W'(1);
        end
      end

      if (state_q == ST_FIN) begin
        busy <= 1'b0;
      end
    end
  end

  bram_line_unpacker_shift_reg #(
    .LANE_W    (LANE_W),
    .BURST_LEN (BURST_LEN)
  ) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state_q == ST_WAIT),
    .shift_en (wr_c),
    .d        (ram_rd_data),
    .q        (shift_q)
  );

endmodule

// File: tb/tb_bram_line_unpacker.sv
// Directed self-checking bench for bram_line_unpacker.
module tb_bram_line_unpacker;

  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned BURST_LEN = 8;
  localparam int unsigned LANE_W    = 16;
  localparam int unsigned OUT_W     = 32;
  localparam int unsigned LINE_W    = LANE_W * BURST_LEN;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                start = 1'b0;
  logic [ADDR_W-1:0]   base_addr = '0;
  logic [ADDR_W:0]     line_count = '0;
  logic [ADDR_W-1:0]   ram_rd_addr;
  logic [LINE_W-1:0]   ram_rd_data = '0;
  logic                fifo_full = 1'b0;
  logic                fifo_wr_en;
  logic [OUT_W-1:0]    fifo_wr_data;
  logic                busy;
  logic                done;
  logic [ADDR_W+3:0]   words_sent;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [LINE_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [31:0] wq [$];
  int          wc [$];
  int          done_cnt = 0;
  int          done_cyc = -1;

  bram_line_unpacker dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_addr    (base_addr),
    .line_count   (line_count),
    .ram_rd_addr  (ram_rd_addr),
    .ram_rd_data  (ram_rd_data),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .busy         (busy),
    .done         (done),
    .words_sent   (words_sent)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) ram_rd_data <= mem[ram_rd_addr];

  // Record FIFO writes and done pulses mid-cycle.
  always @(negedge clk) begin
    if (rst_n && fifo_wr_en) begin
      wq.push_back(fifo_wr_data);
      wc.push_back(cyc);
    end
    if (rst_n && done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // Address 5 holds lanes 0..7; every other line holds addr*16 + lane.
  function automatic logic [15:0] lane_val(input int a, input int i);
    if (a == 5) return 16'(i);
    return 16'(a * 16 + i);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wq.delete();
    wc.delete();
  endtask

  task automatic launch(input int b, input int n, output int sc);
    base_addr  = ADDR_W'(b);
    line_count = (ADDR_W+1)'(n);
    start      = 1'b1;
    sc         = cyc;
    step();
    start      = 1'b0;
  endtask

  task automatic wait_done(input int prev, input int budget, input string name);
    for (int k = 0; k < budget && done_cnt == prev; k++) step();
    if (done_cnt == prev) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no done within %0d cycles", name, budget);
    end
    step();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    checks++; if (ram_rd_addr !== '0)  begin errors++; $display("FAIL reset_addr: got %0h expected 0", ram_rd_addr); end
    checks++; if (fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %0b expected 0", fifo_wr_en); end
    checks++; if (fifo_wr_data !== '0) begin errors++; $display("FAIL reset_wr_data: got %0h expected 0", fifo_wr_data); end
    checks++; if (busy !== 1'b0)       begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
    checks++; if (done !== 1'b0)       begin errors++; $display("FAIL reset_done: got %0b expected 0", done); end
    checks++; if (words_sent !== '0)   begin errors++; $display("FAIL reset_words: got %0d expected 0", words_sent); end
    repeat (20) step();
    checks++; if (wq.size() != 0 || done_cnt != 0) begin
      errors++; $display("FAIL reset_idle: got %0d writes %0d dones expected 0 0", wq.size(), done_cnt);
    end
  endtask

  task automatic test_single_line();
    int sc;
    int prev;
    clear_log();
    prev = done_cnt;
    launch(5, 1, sc);
    checks++; if (busy !== 1'b1 || ram_rd_addr !== 10'd5) begin
      errors++; $display("FAIL single_launch: got busy=%0b addr=%0d expected busy=1 addr=5", busy, ram_rd_addr);
    end
    wait_done(prev, 100, "single");
    checks++; if (wq.size() != 8) begin errors++; $display("FAIL single_count: got %0d expected 8", wq.size()); end
    for (int i = 0; i < 8 && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== 32'(i) || wc[i] != sc + 3 + i) begin
        errors++; $display("FAIL single_word%0d: got %0h@%0d expected %0h@%0d", i, wq[i], wc[i] - sc, i, 3 + i);
      end
    end
    checks++; if (done_cyc != sc + 11) begin errors++; $display("FAIL single_done_cyc: got %0d expected 11", done_cyc - sc); end
    checks++; if (words_sent !== 14'd8 || busy !== 1'b0) begin
      errors++; $display("FAIL single_status: got words=%0d busy=%0b expected 8 0", words_sent, busy);
    end
  endtask

  task automatic test_multi_wrap();
    int sc;
    int prev;
    int a;
    logic [31:0] exp;
    clear_log();
    prev = done_cnt;
    launch(1022, 3, sc);
    wait_done(prev, 200, "wrap");
    checks++; if (wq.size() != 24) begin errors++; $display("FAIL wrap_count: got %0d expected 24", wq.size()); end
    for (int i = 0; i < 24 && i < wq.size(); i++) begin
      a   = (1022 + i / 8) % 1024;
      exp = 32'(lane_val(a, i % 8));
      checks++;
      if (wq[i] !== exp) begin errors++; $display("FAIL wrap_word%0d: got %0h expected %0h", i, wq[i], exp); end
    end
    checks++; if (done_cyc != sc + 31) begin errors++; $display("FAIL wrap_done_cyc: got %0d expected 31", done_cyc - sc); end
    checks++; if (words_sent !== 14'd24) begin errors++; $display("FAIL wrap_words: got %0d expected 24", words_sent); end
  endtask

  task automatic test_backpressure();
    int sc;
    int prev;
    int ec;
    clear_log();
    prev = done_cnt;
    launch(2, 1, sc);
    while (cyc < sc + 6) step();
    fifo_full = 1'b1;
    repeat (4) step();
    fifo_full = 1'b0;
    wait_done(prev, 100, "bp");
    checks++; if (wq.size() != 8) begin errors++; $display("FAIL bp_count: got %0d expected 8", wq.size()); end
    for (int i = 0; i < 8 && i < wq.size(); i++) begin
      ec = sc + 3 + i + ((i >= 3) ? 4 : 0);
      checks++;
      if (wq[i] !== 32'(32 + i) || wc[i] != ec) begin
        errors++; $display("FAIL bp_word%0d: got %0h@%0d expected %0h@%0d", i, wq[i], wc[i] - sc, 32 + i, ec - sc);
      end
    end
    checks++; if (done_cyc != sc + 15) begin errors++; $display("FAIL bp_done_cyc: got %0d expected 15", done_cyc - sc); end
    checks++; if (words_sent !== 14'd8) begin errors++; $display("FAIL bp_words: got %0d expected 8", words_sent); end
  endtask

  task automatic test_zero_and_ignored();
    int sc;
    int prev;
    clear_log();
    prev = done_cnt;
    launch(0, 0, sc);
    wait_done(prev, 20, "zero");
    checks++; if (done_cyc != sc + 1) begin errors++; $display("FAIL zero_done_cyc: got %0d expected 1", done_cyc - sc); end
    checks++; if (wq.size() != 0 || words_sent !== '0) begin
      errors++; $display("FAIL zero_writes: got %0d writes words=%0d expected 0 0", wq.size(), words_sent);
    end

    clear_log();
    prev = done_cnt;
    launch(3, 1, sc);
    while (cyc < sc + 5) step();
    base_addr  = 10'd100;
    line_count = 11'd5;
    start      = 1'b1;
    step();
    start      = 1'b0;
    wait_done(prev, 100, "ign");
    repeat (40) step();
    checks++; if (done_cnt != prev + 1 || done_cyc != sc + 11) begin
      errors++; $display("FAIL ign_done: got %0d dones last@%0d expected 1 @11", done_cnt - prev, done_cyc - sc);
    end
    checks++; if (wq.size() != 8 || words_sent !== 14'd8) begin
      errors++; $display("FAIL ign_count: got %0d writes words=%0d expected 8 8", wq.size(), words_sent);
    end
    for (int i = 0; i < 8 && i < wq.size(); i++) begin
      checks++;
      if (wq[i] !== 32'(48 + i)) begin errors++; $display("FAIL ign_word%0d: got %0h expected %0h", i, wq[i], 48 + i); end
    end
  endtask

  task automatic test_reset_mid_emit();
    int sc;
    int prev;
    clear_log();
    prev = done_cnt;
    launch(4, 2, sc);
    while (cyc < sc + 6) step();
    #2;
    checks++; if (fifo_wr_en !== 1'b1 || wq.size() != 3) begin
      errors++; $display("FAIL rst_pre: got wr_en=%0b writes=%0d expected 1 3", fifo_wr_en, wq.size());
    end
    rst_n = 1'b0;
    #1;
    checks++; if (fifo_wr_en !== 1'b0 || words_sent !== '0 || busy !== 1'b0 || ram_rd_addr !== '0) begin
      errors++; $display("FAIL rst_async: got wr_en=%0b words=%0d busy=%0b addr=%0d expected 0 0 0 0",
                         fifo_wr_en, words_sent, busy, ram_rd_addr);
    end
    repeat (3) step();
    rst_n = 1'b1;
    repeat (30) step();
    checks++; if (done_cnt != prev || wq.size() != 3 || words_sent !== '0) begin
      errors++; $display("FAIL rst_after: got dones=%0d writes=%0d words=%0d expected 0 3 0",
                         done_cnt - prev, wq.size(), words_sent);
    end
  endtask

  initial begin
    for (int a = 0; a < (1 << ADDR_W); a++)
      for (int i = 0; i < BURST_LEN; i++)
        mem[a][i*LANE_W +: LANE_W] = lane_val(a, i);

    test_reset();
    test_single_line();
    test_multi_wrap();
    test_backpressure();
    test_zero_and_ignored();
    test_reset_mid_emit();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
